// File: rtl/color_convert_pkg.sv
// Shared definitions for the colour-conversion filter.
//   mode_e       : per-pixel operating mode (pass / gray / binarize / invert)
//   DefMode      : mode loaded at reset
//   DefCoef*     : reset weights (BT.601 luma in 0.8 fixed point)
package color_convert_pkg;

  typedef enum logic [1:0] {
    ModePass = 2'd0,
    ModeGray = 2'd1,
    ModeBin  = 2'd2,
    ModeInv  = 2'd3
  } mode_e;

  localparam logic [1:0]  DefMode  = 2'd1;
  localparam int unsigned DefCoefR = 77;
  localparam int unsigned DefCoefG = 150;
  localparam int unsigned DefCoefB = 29;

endpackage

// File: rtl/weighted_sum3.sv
// Three-input weighted sum with round-half-up and saturation, two registered stages.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_r/in_g/in_b       : DATA_W-bit samples
//   coef_r/coef_g/coef_b : COEF_W-bit unsigned weights, COEF_W fractional bits
//   gray                 : saturated DATA_W-bit result, valid two cycles after the inputs
module weighted_sum3 #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_g,
  input  logic [DATA_W-1:0] in_b,
  input  logic [COEF_W-1:0] coef_r,
  input  logic [COEF_W-1:0] coef_g,
  input  logic [COEF_W-1:0] coef_b,
  output logic [DATA_W-1:0] gray
);

  localparam int unsigned ProdW = DATA_W + COEF_W;
  // Two guard bits: the sum of three products plus rounding needs at most ProdW+2 bits.
  localparam int unsigned SumW  = ProdW + 2;
  localparam logic [SumW-1:0] RoundC = {{(SumW-1){1'b0}}, 1'b1} << (COEF_W - 1);

  logic [ProdW-1:0]    prod_r_q, prod_g_q, prod_b_q;
  logic [SumW-1:0]     sum;
  logic [DATA_W+1:0]   quot;
  logic [DATA_W-1:0]   gray_d, gray_q;

  // S1: products, operands zero-extended to the full product width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r_q <= '0;
      prod_g_q <= '0;
      prod_b_q <= '0;
    end else begin
      prod_r_q <= {{COEF_W{1'b0}}, in_r} * {{DATA_W{1'b0}}, coef_r};
      prod_g_q <= {{COEF_W{1'b0}}, in_g} * {{DATA_W{1'b0}}, coef_g};
      prod_b_q <= {{COEF_W{1'b0}}, in_b} * {{DATA_W{1'b0}}, coef_b};
    end
  end

  // S2: sum, round, shift out the fraction and clip to full scale.
  always_comb begin
    sum    = {2'b00, prod_r_q} + {2'b00, prod_g_q} + {2'b00, prod_b_q} + RoundC;
    quot   = sum[SumW-1:COEF_W];
    gray_d = (|quot[DATA_W+1:DATA_W]) ? {DATA_W{1'b1}} : quot[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q <= '0;
    end else begin
      gray_q <= gray_d;
    end
  end

  assign gray = gray_q;

endmodule

// File: rtl/color_convert.sv
// Per-pixel colour-conversion filter between the frame reader and the frame writer.
//   clk, rst_n            : clock, asynchronous active-low reset
//   posx, posy            : coordinates of the pixel presented this cycle
//   ready                 : reader has a pixel available
//   enable                : 0 stops pixel consumption
//   rden                  : pixel consumed this cycle (ready & enable)
//   in_r/in_g/in_b        : input pixel
//   mode                  : requested mode (0 pass, 1 gray, 2 binarize, 3 invert)
//   coef_r/coef_g/coef_b  : requested weights
//   thresh                : requested binarize threshold
//   wren                  : output pixel valid, exactly 3 cycles after rden
//   out_r/out_g/out_b     : output pixel, held while wren is low
//   cur_mode              : mode held in the shadow register
// Requested settings are latched only at frame start (rden at pixel 0,0); that pixel
// already uses the new values. Mode and threshold travel with each pixel.
module color_convert
  import color_convert_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned COEF_W   = 8,
  parameter int unsigned POS_W    = 12,
  parameter logic [1:0]  DEF_MODE = DefMode,
  parameter int unsigned DEF_CR   = DefCoefR,
  parameter int unsigned DEF_CG   = DefCoefG,
  parameter int unsigned DEF_CB   = DefCoefB
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [POS_W-1:0]  posx,
  input  logic [POS_W-1:0]  posy,
  input  logic              ready,
  input  logic              enable,
  output logic              rden,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_g,
  input  logic [DATA_W-1:0] in_b,
  input  logic [1:0]        mode,
  input  logic [COEF_W-1:0] coef_r,
  input  logic [COEF_W-1:0] coef_g,
  input  logic [COEF_W-1:0] coef_b,
  input  logic [DATA_W-1:0] thresh,
  output logic              wren,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_g,
  output logic [DATA_W-1:0] out_b,
  output logic [1:0]        cur_mode
);

  localparam logic [DATA_W-1:0] ThreshRst = {1'b1, {(DATA_W-1){1'b0}}};

  logic              frame_start;

  // Shadow settings.
  mode_e             mode_q;
  logic [COEF_W-1:0] coef_r_q, coef_g_q, coef_b_q;
  logic [DATA_W-1:0] thresh_q;

  // Settings applied to the pixel entering this cycle.
  mode_e             eff_mode;
  logic [COEF_W-1:0] eff_coef_r, eff_coef_g, eff_coef_b;
  logic [DATA_W-1:0] eff_thresh;

  // Side-band pipeline alongside weighted_sum3.
  logic              vld_s1_q, vld_s2_q, vld_s3_q;
  logic [DATA_W-1:0] raw_r_s1_q, raw_g_s1_q, raw_b_s1_q;
  logic [DATA_W-1:0] raw_r_s2_q, raw_g_s2_q, raw_b_s2_q;
  mode_e             mode_s1_q, mode_s2_q;
  logic [DATA_W-1:0] thr_s1_q, thr_s2_q;
  logic [DATA_W-1:0] gray_s2;

  logic [DATA_W-1:0] out_r_d, out_g_d, out_b_d;
  logic [DATA_W-1:0] out_r_q, out_g_q, out_b_q;

  assign rden        = ready & enable;
  assign frame_start = rden & (posx == '0) & (posy == '0);

  // Bypass so the frame-start pixel sees the newly requested settings.
  always_comb begin
    eff_mode   = frame_start ? mode_e'(mode) : mode_q;
    eff_coef_r = frame_start ? coef_r : coef_r_q;
    eff_coef_g = frame_start ? coef_g : coef_g_q;
    eff_coef_b = frame_start ? coef_b : coef_b_q;
    eff_thresh = frame_start ? thresh : thresh_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= mode_e'(DEF_MODE);
      coef_r_q <= COEF_W'(DEF_CR);
      coef_g_q <= COEF_W'(DEF_CG);
      coef_b_q <= COEF_W'(DEF_CB);
      thresh_q <= ThreshRst;
    end else if (frame_start) begin
      mode_q   <= mode_e'(mode);
      coef_r_q <= coef_r;
      coef_g_q <= coef_g;
      coef_b_q <= coef_b;
      thresh_q <= thresh;
    end
  end

  weighted_sum3 #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W)
  ) u_weighted_sum3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_r   (in_r),
    .in_g   (in_g),
    .in_b   (in_b),
    .coef_r (eff_coef_r),
    .coef_g (eff_coef_g),
    .coef_b (eff_coef_b),
    .gray   (gray_s2)
  );

  // S1/S2 side-band: data regs follow the inputs every cycle; only the valid bits matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_s1_q   <= 1'b0;
      vld_s2_q   <= 1'b0;
      vld_s3_q   <= 1'b0;
      raw_r_s1_q <= '0;
      raw_g_s1_q <= '0;
      raw_b_s1_q <= '0;
      raw_r_s2_q <= '0;
      raw_g_s2_q <= '0;
      raw_b_s2_q <= '0;
      mode_s1_q  <= ModePass;
      mode_s2_q  <= ModePass;
      thr_s1_q   <= '0;
      thr_s2_q   <= '0;
    end else begin
      vld_s1_q   <= rden;
      vld_s2_q   <= vld_s1_q;
      vld_s3_q   <= vld_s2_q;
      raw_r_s1_q <= in_r;
      raw_g_s1_q <= in_g;
      raw_b_s1_q <= in_b;
      raw_r_s2_q <= raw_r_s1_q;
      raw_g_s2_q <= raw_g_s1_q;
      raw_b_s2_q <= raw_b_s1_q;
      mode_s1_q  <= eff_mode;
      mode_s2_q  <= mode_s1_q;
      thr_s1_q   <= eff_thresh;
      thr_s2_q   <= thr_s1_q;
    end
  end

  // S3 output select; outputs hold when no valid pixel reaches this stage.
  always_comb begin
    out_r_d = out_r_q;
    out_g_d = out_g_q;
    out_b_d = out_b_q;
    if (vld_s2_q) begin
      unique case (mode_s2_q)
        ModePass: begin
          out_r_d = raw_r_s2_q;
          out_g_d = raw_g_s2_q;
          out_b_d = raw_b_s2_q;
        end
        ModeGray: begin
          out_r_d = gray_s2;
          out_g_d = gray_s2;
          out_b_d = gray_s2;
        end
        ModeBin: begin
          out_r_d = (gray_s2 >= thr_s2_q) ? {DATA_W{1'b1}} : '0;
          out_g_d = out_r_d;
          out_b_d = out_r_d;
        end
        ModeInv: begin
          // Full scale minus x is the bitwise complement.
          out_r_d = ~raw_r_s2_q;
          out_g_d = ~raw_g_s2_q;
          out_b_d = ~raw_b_s2_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r_q <= '0;
      out_g_q <= '0;
      out_b_q <= '0;
    end else begin
      out_r_q <= out_r_d;
      out_g_q <= out_g_d;
      out_b_q <= out_b_d;
    end
  end

  assign wren     = vld_s3_q;
  assign out_r    = out_r_q;
  assign out_g    = out_g_q;
  assign out_b    = out_b_q;
  assign cur_mode = mode_q;

endmodule

// File: tb/tb_color_convert.sv
// Scoreboard bench for color_convert: expected pixels are queued as they are consumed and
// compared when wren appears; wren timing is compared against the bench's own rden history.
module tb_color_convert;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] posx, posy;
  logic        ready, enable, rden;
  logic [7:0]  in_r, in_g, in_b;
  logic [1:0]  mode;
  logic [7:0]  coef_r, coef_g, coef_b, thresh;
  logic        wren;
  logic [7:0]  out_r, out_g, out_b;
  logic [1:0]  cur_mode;

  logic [23:0] exp_q[$];
  logic [2:0]  rden_hist;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  color_convert dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .posx     (posx),
    .posy     (posy),
    .ready    (ready),
    .enable   (enable),
    .rden     (rden),
    .in_r     (in_r),
    .in_g     (in_g),
    .in_b     (in_b),
    .mode     (mode),
    .coef_r   (coef_r),
    .coef_g   (coef_g),
    .coef_b   (coef_b),
    .thresh   (thresh),
    .wren     (wren),
    .out_r    (out_r),
    .out_g    (out_g),
    .out_b    (out_b),
    .cur_mode (cur_mode)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Pixels consumed at the last three edges, newest in bit 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rden_hist <= 3'b000;
    else        rden_hist <= {rden_hist[1:0], ready & enable};
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("rden", {31'd0, rden}, {31'd0, ready & enable});
      check_eq("wren", {31'd0, wren}, {31'd0, rden_hist[2]});
      if (wren) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_underflow: got wren=1 with 0 queued, want a queued pixel");
        end else begin
          check_eq("pixel", {8'd0, out_r, out_g, out_b}, {8'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Present one pixel for one cycle; queue its expected output if it is consumed.
  task automatic px(input logic rdy, input logic en, input logic [11:0] x, input logic [11:0] y,
                    input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                    input logic [23:0] e);
    ready  = rdy;
    enable = en;
    posx   = x;
    posy   = y;
    in_r   = r;
    in_g   = g;
    in_b   = b;
    if (rdy && en) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ready = 1'b0;
    posx  = 12'd9;
    posy  = 12'd9;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b1;
    ready  = 1'b0;
    enable = 1'b1;
    posx   = 12'd5;
    posy   = 12'd5;
    in_r   = 8'd0;
    in_g   = 8'd0;
    in_b   = 8'd0;
    mode   = 2'd1;
    coef_r = 8'd77;
    coef_g = 8'd150;
    coef_b = 8'd29;
    thresh = 8'd128;
    #1 rst_n = 1'b0;
    #11;
    check_eq("rst_wren", {31'd0, wren}, 32'd0);
    check_eq("rst_out", {8'd0, out_r, out_g, out_b}, 32'd0);
    check_eq("rst_cur_mode", {30'd0, cur_mode}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Default gray.
    px(1, 1, 0, 0, 255, 255, 255, 24'hFFFFFF);
    px(1, 1, 1, 0, 100, 50, 200, 24'h525252);
    idle(5);

    // Invert, then pass, each taking effect on its frame-start pixel.
    mode = 2'd3;
    px(1, 1, 0, 0, 10, 20, 30, 24'hF5EBE1);
    check_eq("cur_mode_inv", {30'd0, cur_mode}, 32'd3);
    mode = 2'd0;
    px(1, 1, 0, 0, 10, 20, 30, 24'h0A141E);
    check_eq("cur_mode_pass", {30'd0, cur_mode}, 32'd0);
    idle(4);

    // Binarize around 128, including the exact-threshold pixel; mid-frame threshold ignored.
    mode   = 2'd2;
    thresh = 8'd128;
    px(1, 1, 0, 0, 255, 255, 255, 24'hFFFFFF);
    px(1, 1, 1, 0, 100, 50, 200, 24'h000000);
    px(1, 1, 2, 0, 128, 128, 128, 24'hFFFFFF);
    px(1, 1, 3, 0, 127, 127, 127, 24'h000000);
    thresh = 8'd0;
    px(1, 1, 4, 0, 0, 0, 0, 24'h000000);
    idle(4);

    // Saturation, and a mid-frame mode request that must wait for the next frame.
    thresh = 8'd128;
    coef_r = 8'd255;
    coef_g = 8'd255;
    coef_b = 8'd255;
    mode   = 2'd1;
    px(1, 1, 0, 0, 255, 255, 255, 24'hFFFFFF);
    mode = 2'd3;
    px(1, 1, 1, 0, 10, 20, 30, 24'h3C3C3C);
    check_eq("cur_mode_hold", {30'd0, cur_mode}, 32'd1);
    px(1, 1, 0, 0, 10, 20, 30, 24'hF5EBE1);
    check_eq("cur_mode_next", {30'd0, cur_mode}, 32'd3);
    idle(4);

    // Flow pattern 1,0,1,1,0 in pass mode, then enable low while the reader is ready.
    coef_r = 8'd77;
    coef_g = 8'd150;
    coef_b = 8'd29;
    mode   = 2'd0;
    px(1, 1, 0, 0, 8'h01, 8'h02, 8'h03, 24'h010203);
    px(0, 1, 1, 0, 8'h04, 8'h05, 8'h06, 24'h040506);
    px(1, 1, 1, 0, 8'h07, 8'h08, 8'h09, 24'h070809);
    px(1, 1, 2, 0, 8'hA0, 8'hB0, 8'hC0, 24'hA0B0C0);
    px(0, 1, 3, 0, 8'hDD, 8'hEE, 8'hFF, 24'hDDEEFF);
    for (int i = 0; i < 5; i++) px(1, 0, 12'(4 + i), 0, 8'h55, 8'h66, 8'h77, 24'h556677);
    idle(3);

    // Reset with two pixels in flight.
    px(1, 1, 7, 7, 8'h11, 8'h22, 8'h33, 24'h112233);
    px(1, 1, 8, 7, 8'h44, 8'h55, 8'h66, 24'h445566);
    ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_wren", {31'd0, wren}, 32'd0);
    check_eq("arst_out", {8'd0, out_r, out_g, out_b}, 32'd0);
    check_eq("arst_cur_mode", {30'd0, cur_mode}, 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(5);
    px(1, 1, 5, 5, 100, 50, 200, 24'h525252);
    idle(6);
    check_eq("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/color_convert.md
Name: color_convert

Overview:
- Parametrised per-pixel colour-conversion filter; next generation of the fixed 8-bit grayscale stage.
- Sits in the image-processing filter chain between the frame reader (POSX/POSY/READY/RDEN) and the frame writer (WREN/OUT_*).
- Selectable modes: passthrough, weighted grayscale, binarize and invert. Coefficients and threshold are runtime-programmable.
- Mode, coefficients and threshold change only at frame boundaries.

Parameters:
DATA_W, 8, bits per colour channel
COEF_W, 8, bits per weight coefficient (unsigned; fixed point, COEF_W fractional bits)
POS_W, 12, width of POSX/POSY
DEF_MODE, 1, mode loaded at reset (1 = gray)
DEF_CR / DEF_CG / DEF_CB, 77 / 150 / 29, reset coefficients

Ports:
CLK  in  1  clock
RST_N  in  1  reset, asynchronous, active-low
POSX  in  POS_W  x-coordinate of the pixel presented this cycle
POSY  in  POS_W  y-coordinate of the pixel presented this cycle
READY  in  1  reader has a pixel available
ENABLE  in  1  0 = block stops consuming pixels
RDEN  out  1  pixel consumed this cycle
IN_R / IN_G / IN_B  in  DATA_W each  input pixel
MODE  in  2  requested mode: 0 pass, 1 gray, 2 binarize, 3 invert
COEF_R / COEF_G / COEF_B  in  COEF_W each  requested weights
THRESH  in  DATA_W  requested binarize threshold
WREN  out  1  output pixel valid
OUT_R / OUT_G / OUT_B  out  DATA_W each  output pixel
CUR_MODE  out  2  mode currently applied (shadow)

Behaviour:
- Reset (RST_N low, asynchronous): all pipeline data, WREN and OUT_* = 0.
  - Valid shift register = 0.
  - Shadow mode = DEF_MODE, shadow coefficients = DEF_C*, shadow threshold = 2^(DATA_W-1).
  - WREN deasserts within the reset assertion, not at the next edge.
- RDEN = READY & ENABLE (combinational). This block applies no backpressure downstream.
- Frame start = RDEN & POSX==0 & POSY==0.
  - At frame start, MODE/COEF_*/THRESH are captured into the shadow registers.
  - That pixel already uses the new shadow values (bypass mux).
  - Requested-value changes at any other time are ignored until the next frame start.
- Pipeline is 3 stages, fixed latency 3: WREN(t+3) = RDEN(t), exact pattern preserved, no bubbles added.
  - S1: products P_c = IN_c * COEF_c, each DATA_W+COEF_W bits. Raw pixel and shadow mode/threshold are carried alongside.
  - S2: SUM = P_r + P_g + P_b + 2^(COEF_W-1) (round-half-up), DATA_W+COEF_W+2 bits. GRAY = SUM >> COEF_W, saturated to 2^DATA_W-1.
  - S3 output register, by mode:
    - pass: OUT = raw.
    - gray: all three channels = GRAY.
    - binarize: all channels = (GRAY >= THRESH) ? 2^DATA_W-1 : 0.
    - invert: OUT_c = (2^DATA_W-1) - raw_c.
- OUT_* update only when the S3 valid bit is 1; otherwise they hold their last value.
- Mode is carried per pixel through the pipeline. A frame boundary therefore never mixes modes within a pixel, and in-flight pixels keep their mode.
- ENABLE low mid-frame: no new pixels enter; in-flight pixels still drain and emit WREN.
- Reset mid-operation: in-flight pixels are discarded and no WREN is produced for them after release.
- CUR_MODE reflects the shadow mode register (updates the cycle after frame start).

Decomposition:
- Shared header colorconv_defs.vh holds:
  - mode encodings MODE_PASS=0, MODE_GRAY=1, MODE_BIN=2, MODE_INV=3;
  - default coefficient values.
- One sub-module, weighted_sum3: 3-input multiply, round, saturate.
  - Two registered stages (S1, S2).
  - Parameters DATA_W, COEF_W.
  - Reused later by colour-space filters.

Test Plan:
- Reset defaults, gray mode, pixels (255,255,255) then (100,50,200), READY held 1 -> WREN rises 3 cycles after first RDEN; outputs 255/255/255 then 82/82/82.
- Frame start with MODE=3, pixel (10,20,30) -> (245,235,225); MODE=0 same pixel -> (10,20,30).
- Frame start with MODE=2, THRESH=128:
  - (255,255,255) -> 255s;
  - (100,50,200) -> 0s;
  - gray exactly 128 -> 255s.
- Saturation: COEF_* = 255, input (255,255,255), gray mode -> 255 (raw quotient 762 clipped). Change MODE to 3 mid-frame -> no effect until the next POSX=POSY=0 pixel, and CUR_MODE then changes.
- Flow pattern: READY sequence 1,0,1,1,0 with ENABLE=1 -> WREN shows 1,0,1,1,0 delayed 3 cycles. ENABLE=0 -> RDEN=0 and WREN drains to 0.
- Async reset pulsed with 2 pixels in flight -> WREN and OUT_* go 0 immediately; no WREN after release until new RDEN+3.
